// File: rtl/fetch_circuit.sv
// Basic-computer datapath slice: sequence counter with T0-T7 decode, 16-bit common bus,
// AR/PC/IR/DR/AC/TR/OUTR registers and a 4096x16 memory, running the fetch and interrupt cycles.
module fetch_circuit (
  input  logic        clk,
  input  logic        rst_n,
  output logic [2:0]  s,
  input  logic        write,
  input  logic        sc_inr,
  input  logic        sc_clr,
  input  logic        pc_ld,
  input  logic        pc_clr,
  input  logic        dr_ld,
  input  logic        dr_inr,
  input  logic        dr_clr,
  input  logic        tr_ld,
  input  logic        tr_inr,
  input  logic        tr_clr,
  input  logic        outr_ld,
  input  logic        r,
  output logic [15:0] sys_bus,
  output logic [11:0] w_ar_data,
  output logic [11:0] w_pc_data,
  output logic [15:0] w_ir_data,
  output logic [15:0] w_mem_data,
  output logic [15:0] w_dr_data,
  output logic [15:0] w_ac_data,
  output logic [15:0] w_tr_data,
  output logic [7:0]  inp_r
);

  logic [2:0]  sc_q, sc_d;
  logic [11:0] ar_q, ar_d;
  logic [11:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] dr_q, dr_d;
  logic [15:0] ac_q, ac_d;
  logic [15:0] tr_q, tr_d;
  logic [7:0]  outr_q, outr_d;
  logic [15:0] mem_q [0:4095];

  logic [7:0]  t_s;
  logic        fet0_s, fet1_s, fet2_s, int0_s, int1_s, int2_s;
  logic [2:0]  sel_s;
  logic [15:0] bus_s;
  logic [15:0] mem_rd_s;
  logic        mem_we_s;
  logic        pc_clr_s, pc_inr_s, tr_ld_s;

  // Timing decode and the fetch/interrupt micro-op qualifiers
  always_comb begin
    t_s    = 8'd1 << sc_q;
    fet0_s = ~r & t_s[0];
    fet1_s = ~r & t_s[1];
    fet2_s = ~r & t_s[2];
    int0_s = r & t_s[0];
    int1_s = r & t_s[1];
    int2_s = r & t_s[2];
  end

  // Bus source select: only the internal micro-ops ever choose a source
  always_comb begin
    sel_s = 3'd0;
    if (t_s[0]) begin
      sel_s = 3'd2;
    end else if (fet1_s) begin
      sel_s = 3'd7;
    end else if (int1_s) begin
      sel_s = 3'd6;
    end else if (fet2_s) begin
      sel_s = 3'd5;
    end else begin
      sel_s = 3'd0;
    end
  end

  // Common bus multiplexer
  always_comb begin
    mem_rd_s = mem_q[ar_q];
    bus_s    = 16'h0000;
    case (sel_s)
      3'd0:    bus_s = 16'h0000;
      3'd1:    bus_s = {4'h0, ar_q};
      3'd2:    bus_s = {4'h0, pc_q};
      3'd3:    bus_s = dr_q;
      3'd4:    bus_s = ac_q;
      3'd5:    bus_s = ir_q;
      3'd6:    bus_s = tr_q;
      3'd7:    bus_s = mem_rd_s;
      default: bus_s = 16'h0000;
    endcase
  end

  // Next-state for every register; clear beats load beats increment
  always_comb begin
    pc_clr_s = pc_clr | int1_s;
    pc_inr_s = fet1_s | int2_s;
    tr_ld_s  = tr_ld | int0_s;
    mem_we_s = write | int1_s;

    if (sc_clr | int2_s) begin
      sc_d = 3'd0;
    end else if (sc_inr) begin
      sc_d = sc_q + 3'd1;
    end else begin
      sc_d = sc_q;
    end

    if (int0_s) begin
      ar_d = 12'd0;
    end else if (fet0_s | fet2_s) begin
      ar_d = bus_s[11:0];
    end else begin
      ar_d = ar_q;
    end

    if (pc_clr_s) begin
      pc_d = 12'd0;
    end else if (pc_ld) begin
      pc_d = bus_s[11:0];
    end else if (pc_inr_s) begin
      pc_d = pc_q + 12'd1;
    end else begin
      pc_d = pc_q;
    end

    if (fet1_s) begin
      ir_d = bus_s;
    end else begin
      ir_d = ir_q;
    end

    if (dr_clr) begin
      dr_d = 16'd0;
    end else if (dr_ld) begin
      dr_d = bus_s;
    end else if (dr_inr) begin
      dr_d = dr_q + 16'd1;
    end else begin
      dr_d = dr_q;
    end

    if (tr_clr) begin
      tr_d = 16'd0;
    end else if (tr_ld_s) begin
      tr_d = bus_s;
    end else if (tr_inr) begin
      tr_d = tr_q + 16'd1;
    end else begin
      tr_d = tr_q;
    end

    if (outr_ld) begin
      outr_d = bus_s[7:0];
    end else begin
      outr_d = outr_q;
    end

    ac_d = ac_q;
  end

  // Register bank with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc_q   <= 3'd0;
      ar_q   <= 12'd0;
      pc_q   <= 12'd0;
      ir_q   <= 16'd0;
      dr_q   <= 16'd0;
      ac_q   <= 16'd0;
      tr_q   <= 16'd0;
      outr_q <= 8'd0;
    end else begin
      sc_q   <= sc_d;
      ar_q   <= ar_d;
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      dr_q   <= dr_d;
      ac_q   <= ac_d;
      tr_q   <= tr_d;
      outr_q <= outr_d;
    end
  end

  // Memory keeps its contents through reset; writes are blocked while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_s) begin
      mem_q[ar_q] <= bus_s;
    end
  end

  assign s          = sel_s;
  assign sys_bus    = bus_s;
  assign w_ar_data  = ar_q;
  assign w_pc_data  = pc_q;
  assign w_ir_data  = ir_q;
  assign w_mem_data = mem_rd_s;
  assign w_dr_data  = dr_q;
  assign w_ac_data  = ac_q;
  assign w_tr_data  = tr_q;
  assign inp_r      = outr_q;

endmodule

// File: tb/tb_fetch_circuit.sv
// Randomized and directed bench for fetch_circuit against a micro-operation level reference model.
module tb_fetch_circuit;

  logic clk, rst_n;
  logic write, sc_inr, sc_clr, pc_ld, pc_clr, dr_ld, dr_inr, dr_clr;
  logic tr_ld, tr_inr, tr_clr, outr_ld, r;
  logic [2:0]  s;
  logic [15:0] sys_bus, w_ir_data, w_mem_data, w_dr_data, w_ac_data, w_tr_data;
  logic [11:0] w_ar_data, w_pc_data;
  logic [7:0]  inp_r;

  int n_checks = 0;
  int n_errors = 0;

  fetch_circuit dut (
    .clk(clk), .rst_n(rst_n), .s(s), .write(write), .sc_inr(sc_inr), .sc_clr(sc_clr),
    .pc_ld(pc_ld), .pc_clr(pc_clr), .dr_ld(dr_ld), .dr_inr(dr_inr), .dr_clr(dr_clr),
    .tr_ld(tr_ld), .tr_inr(tr_inr), .tr_clr(tr_clr), .outr_ld(outr_ld), .r(r),
    .sys_bus(sys_bus), .w_ar_data(w_ar_data), .w_pc_data(w_pc_data), .w_ir_data(w_ir_data),
    .w_mem_data(w_mem_data), .w_dr_data(w_dr_data), .w_ac_data(w_ac_data),
    .w_tr_data(w_tr_data), .inp_r(inp_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int          m_sc, m_ar, m_pc, m_ir, m_dr, m_ac, m_tr, m_outr;
  int          m_mem [4096];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_sel();
    case (m_sc)
      0:       return 2;
      1:       return r ? 6 : 7;
      2:       return r ? 0 : 5;
      default: return 0;
    endcase
  endfunction

  function automatic int model_bus();
    case (model_sel())
      1:       return m_ar;
      2:       return m_pc;
      3:       return m_dr;
      4:       return m_ac;
      5:       return m_ir;
      6:       return m_tr;
      7:       return m_mem[m_ar];
      default: return 0;
    endcase
  endfunction

  // Apply one clock edge to the model using the inputs currently driven
  task automatic model_edge();
    int b, n_sc, n_ar, n_pc, n_ir, n_dr, n_tr, n_outr;
    if (!rst_n) begin
      m_sc = 0; m_ar = 0; m_pc = 0; m_ir = 0; m_dr = 0; m_ac = 0; m_tr = 0; m_outr = 0;
      return;
    end
    b = model_bus();
    n_sc = m_sc; n_ar = m_ar; n_pc = m_pc; n_ir = m_ir;
    n_dr = m_dr; n_tr = m_tr; n_outr = m_outr;
    if (m_sc == 0) n_ar = r ? 0 : m_pc;
    if (m_sc == 2 && !r) n_ar = m_ir % 4096;
    if (m_sc == 1 && !r) n_ir = b;
    if (pc_clr || (r && m_sc == 1)) n_pc = 0;
    else if (pc_ld) n_pc = b % 4096;
    else if ((!r && m_sc == 1) || (r && m_sc == 2)) n_pc = (m_pc + 1) % 4096;
    if (dr_clr) n_dr = 0;
    else if (dr_ld) n_dr = b;
    else if (dr_inr) n_dr = (m_dr + 1) % 65536;
    if (tr_clr) n_tr = 0;
    else if (tr_ld || (r && m_sc == 0)) n_tr = b;
    else if (tr_inr) n_tr = (m_tr + 1) % 65536;
    if (outr_ld) n_outr = b % 256;
    if (write || (r && m_sc == 1)) m_mem[m_ar] = b;
    if (sc_clr || (r && m_sc == 2)) n_sc = 0;
    else if (sc_inr) n_sc = (m_sc + 1) % 8;
    m_sc = n_sc; m_ar = n_ar; m_pc = n_pc; m_ir = n_ir;
    m_dr = n_dr; m_tr = n_tr; m_outr = n_outr;
  endtask

  task automatic check_all();
    chk("s", {13'd0, s}, 16'(model_sel()));
    chk("bus", sys_bus, 16'(model_bus()));
    chk("ar", {4'd0, w_ar_data}, 16'(m_ar));
    chk("pc", {4'd0, w_pc_data}, 16'(m_pc));
    chk("ir", w_ir_data, 16'(m_ir));
    chk("mem", w_mem_data, 16'(m_mem[m_ar]));
    chk("dr", w_dr_data, 16'(m_dr));
    chk("ac", w_ac_data, 16'(m_ac));
    chk("tr", w_tr_data, 16'(m_tr));
    chk("outr", {8'd0, inp_r}, 16'(m_outr));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clr_strobes();
    write = 1'b0; sc_inr = 1'b0; sc_clr = 1'b0; pc_ld = 1'b0; pc_clr = 1'b0;
    dr_ld = 1'b0; dr_inr = 1'b0; dr_clr = 1'b0; tr_ld = 1'b0; tr_inr = 1'b0;
    tr_clr = 1'b0; outr_ld = 1'b0; r = 1'b0;
  endtask

  task automatic rand_strobes(input int pct);
    write  = ($urandom_range(99) < pct); sc_inr = ($urandom_range(99) < 80);
    sc_clr = ($urandom_range(99) < pct); pc_ld  = ($urandom_range(99) < pct);
    pc_clr = ($urandom_range(99) < pct); dr_ld  = ($urandom_range(99) < pct);
    dr_inr = ($urandom_range(99) < 30);  dr_clr = ($urandom_range(99) < pct);
    tr_ld  = ($urandom_range(99) < pct); tr_inr = ($urandom_range(99) < 30);
    tr_clr = ($urandom_range(99) < pct); outr_ld = ($urandom_range(99) < 20);
    r      = ($urandom_range(99) < 15);
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = 0;
    m_sc = 0; m_ar = 0; m_pc = 0; m_ir = 0; m_dr = 0; m_ac = 0; m_tr = 0; m_outr = 0;

    // Reset with random strobes
    rst_n = 1'b0;
    rand_strobes(50);
    tick();
    rand_strobes(50);
    tick();
    clr_strobes();
    #1;
    chk("rst_s", {13'd0, s}, 16'd2);
    chk("rst_bus", sys_bus, 16'h0000);
    chk("rst_pc", {4'd0, w_pc_data}, 16'h0000);

    // Fetch loop over zero memory
    rst_n = 1'b1;
    sc_inr = 1'b1;
    tick();
    chk("f_t0_ar", {4'd0, w_ar_data}, 16'd0);
    tick();
    chk("f_t1_pc", {4'd0, w_pc_data}, 16'd1);
    chk("f_t1_ir", w_ir_data, 16'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("f_wrap_s", {13'd0, s}, 16'd2);
    tick();
    chk("f2_t0_ar", {4'd0, w_ar_data}, 16'd1);
    tick();
    chk("f2_t1_pc", {4'd0, w_pc_data}, 16'd2);
    // Three more full fetch cycles bring PC to 5 with SC back at 0
    for (int i = 0; i < 30; i++) tick();
    chk("pre_int_pc", {4'd0, w_pc_data}, 16'd5);

    // Interrupt cycle
    r = 1'b1;
    tick();
    chk("i_t0_tr", w_tr_data, 16'd5);
    chk("i_t0_ar", {4'd0, w_ar_data}, 16'd0);
    tick();
    chk("i_t1_pc", {4'd0, w_pc_data}, 16'd0);
    chk("i_t1_mem", w_mem_data, 16'd5);
    tick();
    chk("i_t2_pc", {4'd0, w_pc_data}, 16'd1);
    r = 1'b0;
    #1;
    chk("i_t2_s", {13'd0, s}, 16'd2);
    tick();
    chk("post_int_ar", {4'd0, w_ar_data}, 16'd1);

    // SC control: clear wins, then hold
    sc_clr = 1'b1;
    tick();
    chk("sc_clr_s", {13'd0, s}, 16'd2);
    sc_clr = 1'b0;
    tick();
    sc_inr = 1'b0;
    tick();
    tick();
    chk("sc_hold_s", {13'd0, s}, 16'd7);

    // Walk to T3 and exercise DR/TR strobes on a zero bus
    sc_inr = 1'b1;
    tick();
    tick();
    sc_inr = 1'b0;
    dr_clr = 1'b1;
    tick();
    dr_clr = 1'b0;
    dr_inr = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("dr_inr3", w_dr_data, 16'd3);
    dr_inr = 1'b0; dr_ld = 1'b1;
    tick();
    chk("dr_ld0", w_dr_data, 16'd0);
    dr_ld = 1'b0; tr_clr = 1'b1; tr_inr = 1'b1;
    tick();
    chk("tr_clr_inr", w_tr_data, 16'd0);
    tr_clr = 1'b0; tr_inr = 1'b0;

    // Back to T0, then load TR/OUTR from PC and write memory
    sc_clr = 1'b1;
    tick();
    sc_clr = 1'b0;
    tr_ld = 1'b1; outr_ld = 1'b1; write = 1'b1;
    tick();
    chk("tr_ld_t0", w_tr_data, 16'(m_pc));
    tr_ld = 1'b0; outr_ld = 1'b0; write = 1'b0;

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      rand_strobes(8);
      rst_n = ($urandom_range(99) >= 2);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
